// File: rtl/exe_stage_bru_pkg.sv
// Shared definitions for the execute-stage branch resolution unit:
// branch-selector bit indices, bus widths and FSM state encodings.
package exe_stage_bru_pkg;

  localparam int REG_BUS = 64;
  localparam int BJ_BUS  = 8;

  // One-hot bit positions inside bj_sel / bj_data
  localparam int BJ_BEQ  = 0;
  localparam int BJ_BNE  = 1;
  localparam int BJ_BLT  = 2;
  localparam int BJ_BGE  = 3;
  localparam int BJ_BLTU = 4;
  localparam int BJ_BGEU = 5;
  localparam int BJ_JAL  = 6;
  localparam int BJ_JALR = 7;

  typedef enum logic [0:0] {
    BRU_IDLE = 1'b0,
    BRU_PEND = 1'b1
  } bru_state_e;

  function automatic logic bru_is_link(input logic [BJ_BUS-1:0] sel);
    return sel[BJ_JAL] | sel[BJ_JALR];
  endfunction

endpackage

// File: rtl/exe_stage_bru_cond.sv
// Combinational branch decode: taken decision, target address, alignment
// check and link value for the instruction currently in execute.
module exe_stage_bru_cond
  import exe_stage_bru_pkg::*;
#(
  parameter int XLEN = 64,
  parameter int BJ_W = 8,
  parameter bit RVC  = 1'b0
) (
  input  logic [BJ_W-1:0] bj_sel_i,
  input  logic [BJ_W-1:0] bj_data_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] imm_i,
  input  logic [XLEN-1:0] rs1_val_i,
  output logic            taken_o,
  output logic [XLEN-1:0] target_o,
  output logic            misaligned_o,
  output logic            is_link_o,
  output logic [XLEN-1:0] link_pc_o
);

  logic [BJ_W-1:0] taken_vec;
  logic [XLEN-1:0] jalr_sum;
  logic [XLEN-1:0] pc_rel;
  logic [1:0]      unused_jump_bits;

  // The ALU reports "operands differ" on the BEQ bit, so BEQ/BNE swap.
  always_comb begin
    taken_vec          = '0;
    taken_vec[BJ_BEQ]  = bj_data_i[BJ_BNE];
    taken_vec[BJ_BNE]  = bj_data_i[BJ_BEQ];
    taken_vec[BJ_BLT]  = bj_data_i[BJ_BLT];
    taken_vec[BJ_BGE]  = bj_data_i[BJ_BGE];
    taken_vec[BJ_BLTU] = bj_data_i[BJ_BLTU];
    taken_vec[BJ_BGEU] = bj_data_i[BJ_BGEU];
    taken_vec[BJ_JAL]  = 1'b1;
    taken_vec[BJ_JALR] = 1'b1;
  end

  assign unused_jump_bits = bj_data_i[BJ_JALR:BJ_JAL];

  assign taken_o  = |(bj_sel_i & taken_vec);
  assign jalr_sum = rs1_val_i + imm_i;
  assign pc_rel   = pc_i + imm_i;

  always_comb begin
    target_o = pc_rel;
    if (bj_sel_i[BJ_JALR]) begin
      target_o = {jalr_sum[XLEN-1:1], 1'b0};
    end
  end

  assign misaligned_o = (RVC == 1'b0) && target_o[1];
  assign is_link_o    = bru_is_link(bj_sel_i[BJ_BUS-1:0]);
  assign link_pc_o    = pc_i + XLEN'(4);

endmodule

// File: rtl/exe_stage_bru.sv
// Execute-stage branch resolution unit: resolves control flow with static
// not-taken prediction and issues a registered PC redirect to fetch.
module exe_stage_bru
  import exe_stage_bru_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int BJ_W  = 8,
  parameter bit RVC   = 1'b0,
  parameter int CNT_W = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ex_valid,
  output logic             ex_ready,
  input  logic [BJ_W-1:0]  bj_sel,
  input  logic [BJ_W-1:0]  bj_data,
  input  logic [XLEN-1:0]  pc,
  input  logic [XLEN-1:0]  imm,
  input  logic [XLEN-1:0]  rs1_val,
  input  logic             kill,
  output logic             redirect_valid,
  input  logic             redirect_ready,
  output logic [XLEN-1:0]  redirect_pc,
  output logic             flush_o,
  output logic             link_valid,
  output logic [XLEN-1:0]  link_data,
  output logic             exc_valid,
  output logic [XLEN-1:0]  exc_tval,
  output logic [CNT_W-1:0] br_cnt,
  output logic [CNT_W-1:0] taken_cnt,
  output bru_state_e       dbg_state
);

  bru_state_e       state_q;
  logic [XLEN-1:0]  redirect_pc_q;
  logic             link_valid_q;
  logic [XLEN-1:0]  link_data_q;
  logic             exc_valid_q;
  logic [XLEN-1:0]  exc_tval_q;
  logic [CNT_W-1:0] br_cnt_q;
  logic [CNT_W-1:0] taken_cnt_q;

  logic             taken;
  logic [XLEN-1:0]  target;
  logic             misaligned;
  logic             is_link;
  logic [XLEN-1:0]  link_pc;
  logic             accept;
  logic             handshake;

  exe_stage_bru_cond #(
    .XLEN (XLEN),
    .BJ_W (BJ_W),
    .RVC  (RVC)
  ) u_cond (
    .bj_sel_i     (bj_sel),
    .bj_data_i    (bj_data),
    .pc_i         (pc),
    .imm_i        (imm),
    .rs1_val_i    (rs1_val),
    .taken_o      (taken),
    .target_o     (target),
    .misaligned_o (misaligned),
    .is_link_o    (is_link),
    .link_pc_o    (link_pc)
  );

  // Handshakes: execute transfers when ex_valid & ex_ready; the redirect
  // transfers when redirect_valid & redirect_ready. redirect_valid and
  // redirect_pc stay stable until that transfer, or until kill/rst drops it.
  assign ex_ready  = (state_q == BRU_IDLE);
  assign accept    = ex_valid & ex_ready & (|bj_sel) & ~kill;
  assign handshake = (state_q == BRU_PEND) & redirect_ready & ~kill & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= BRU_IDLE;
      redirect_pc_q <= '0;
      link_valid_q  <= 1'b0;
      link_data_q   <= '0;
      exc_valid_q   <= 1'b0;
      exc_tval_q    <= '0;
      br_cnt_q      <= '0;
      taken_cnt_q   <= '0;
    end else begin
      link_valid_q <= 1'b0;
      exc_valid_q  <= 1'b0;
      if (kill) begin
        state_q <= BRU_IDLE;
      end else begin
        case (state_q)
          BRU_IDLE: begin
            if (accept) begin
              br_cnt_q <= br_cnt_q + CNT_W'(1);
              if (is_link) begin
                link_valid_q <= 1'b1;
                link_data_q  <= link_pc;
              end
              if (taken && misaligned) begin
                exc_valid_q <= 1'b1;
                exc_tval_q  <= target;
              end else if (taken) begin
                redirect_pc_q <= target;
                state_q       <= BRU_PEND;
              end
            end
          end
          BRU_PEND: begin
            if (redirect_ready) begin
              taken_cnt_q <= taken_cnt_q + CNT_W'(1);
              state_q     <= BRU_IDLE;
            end
          end
          default: state_q <= BRU_IDLE;
        endcase
      end
    end
  end

  assign redirect_valid = (state_q == BRU_PEND);
  assign redirect_pc    = redirect_pc_q;
  assign flush_o        = handshake;
  assign link_valid     = link_valid_q;
  assign link_data      = link_data_q;
  assign exc_valid      = exc_valid_q;
  assign exc_tval       = exc_tval_q;
  assign br_cnt         = br_cnt_q;
  assign taken_cnt      = taken_cnt_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_exe_stage_bru.sv
// Bench for exe_stage_bru: directed branch/jump vectors, expected redirect,
// link and exception responses queued and checked by an output monitor.
module tb_exe_stage_bru;
  import exe_stage_bru_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid, c_ex_valid;
  logic [7:0]  bj_sel, bj_data;
  logic [63:0] pc, imm, rs1_val;
  logic        kill;
  logic        redirect_ready, c_ready;

  logic        ex_ready, redirect_valid, flush_o, link_valid, exc_valid;
  logic [63:0] redirect_pc, link_data, exc_tval, br_cnt, taken_cnt;
  bru_state_e  dbg_state;

  logic        c_ex_ready, c_redirect_valid, c_flush, c_link_valid, c_exc_valid;
  logic [63:0] c_redirect_pc, c_link_data, c_exc_tval, c_br_cnt, c_taken_cnt;
  bru_state_e  c_dbg_state;

  logic [63:0] redir_q[$];
  logic [63:0] link_q[$];
  logic [63:0] exc_q[$];

  int n_cmp = 0;
  int n_err = 0;
  int n_flush = 0;
  logic [63:0] exp_br = 0;
  logic [63:0] exp_taken = 0;

  exe_stage_bru #(.XLEN(64), .BJ_W(8), .RVC(1'b0), .CNT_W(64)) dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_ready(ex_ready),
    .bj_sel(bj_sel), .bj_data(bj_data), .pc(pc), .imm(imm), .rs1_val(rs1_val),
    .kill(kill), .redirect_valid(redirect_valid), .redirect_ready(redirect_ready),
    .redirect_pc(redirect_pc), .flush_o(flush_o), .link_valid(link_valid),
    .link_data(link_data), .exc_valid(exc_valid), .exc_tval(exc_tval),
    .br_cnt(br_cnt), .taken_cnt(taken_cnt), .dbg_state(dbg_state)
  );

  exe_stage_bru #(.XLEN(64), .BJ_W(8), .RVC(1'b1), .CNT_W(64)) dut_c (
    .clk(clk), .rst(rst), .ex_valid(c_ex_valid), .ex_ready(c_ex_ready),
    .bj_sel(bj_sel), .bj_data(bj_data), .pc(pc), .imm(imm), .rs1_val(rs1_val),
    .kill(1'b0), .redirect_valid(c_redirect_valid), .redirect_ready(c_ready),
    .redirect_pc(c_redirect_pc), .flush_o(c_flush), .link_valid(c_link_valid),
    .link_data(c_link_data), .exc_valid(c_exc_valid), .exc_tval(c_exc_tval),
    .br_cnt(c_br_cnt), .taken_cnt(c_taken_cnt), .dbg_state(c_dbg_state)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: every output event must match the head of its expected queue
  always @(negedge clk) begin
    if (link_valid === 1'b1) begin
      if (link_q.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL link_unexpected: got %h expected none", link_data);
      end else chk("link_data", link_data, link_q.pop_front());
    end
    if (exc_valid === 1'b1) begin
      if (exc_q.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL exc_unexpected: got %h expected none", exc_tval);
      end else chk("exc_tval", exc_tval, exc_q.pop_front());
    end
    if (flush_o === 1'b1) begin
      n_flush++;
      if (redir_q.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL flush_unexpected: got %h expected none", redirect_pc);
      end else chk("redirect_pc_at_flush", redirect_pc, redir_q.pop_front());
    end
  end

  // Driver tasks
  task automatic issue(input logic [7:0] sel, input logic [7:0] data,
                       input logic [63:0] p, input logic [63:0] im,
                       input logic [63:0] r1, input logic k, input logic c);
    @(posedge clk); #1;
    ex_valid = 1'b1; c_ex_valid = c; kill = k;
    bj_sel = sel; bj_data = data; pc = p; imm = im; rs1_val = r1;
    @(posedge clk); #1;
    ex_valid = 1'b0; c_ex_valid = 1'b0; kill = 1'b0;
    bj_sel = '0; bj_data = '0;
  endtask

  task automatic finish_redirect();
    redirect_ready = 1'b1;
    @(posedge clk); #1;
    redirect_ready = 1'b0;
    exp_taken++;
  endtask

  initial begin
    int f0;
    rst = 1'b1; ex_valid = 0; c_ex_valid = 0; bj_sel = 0; bj_data = 0;
    pc = 0; imm = 0; rs1_val = 0; kill = 0; redirect_ready = 0; c_ready = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ex_ready", {63'd0, ex_ready}, 64'd1);
    chk("rst_redirect_valid", {63'd0, redirect_valid}, 64'd0);
    chk("rst_br_cnt", br_cnt, 64'd0);
    chk("rst_taken_cnt", taken_cnt, 64'd0);
    rst = 1'b0;

    // BEQ taken (operands equal -> BNE bit set)
    redir_q.push_back(64'h8000_0010);
    issue(8'h01, 8'hC2, 64'h8000_0000, 64'h10, 64'h0, 1'b0, 1'b0);
    exp_br++;
    chk("beq_redirect_valid", {63'd0, redirect_valid}, 64'd1);
    chk("beq_redirect_pc", redirect_pc, 64'h8000_0010);
    chk("beq_ex_ready", {63'd0, ex_ready}, 64'd0);
    finish_redirect();
    chk("beq_taken_cnt", taken_cnt, exp_taken);
    chk("beq_br_cnt", br_cnt, exp_br);
    chk("beq_ex_ready_after", {63'd0, ex_ready}, 64'd1);

    // BNE not taken (operands equal -> BEQ bit clear)
    issue(8'h02, 8'hC2, 64'h8000_0020, 64'h40, 64'h0, 1'b0, 1'b0);
    exp_br++;
    chk("bne_redirect_valid", {63'd0, redirect_valid}, 64'd0);
    chk("bne_ex_ready", {63'd0, ex_ready}, 64'd1);
    chk("bne_br_cnt", br_cnt, exp_br);
    chk("bne_taken_cnt", taken_cnt, exp_taken);

    // BLT taken with negative offset
    redir_q.push_back(64'h0000_0FF8);
    issue(8'h04, 8'hC4, 64'h1000, 64'hFFFF_FFFF_FFFF_FFF8, 64'h0, 1'b0, 1'b0);
    exp_br++;
    chk("blt_redirect_pc", redirect_pc, 64'h0FF8);
    finish_redirect();

    // BGEU not taken (less-unsigned)
    issue(8'h20, 8'hD0, 64'h1100, 64'h80, 64'h0, 1'b0, 1'b0);
    exp_br++;
    chk("bgeu_redirect_valid", {63'd0, redirect_valid}, 64'd0);

    // BNE taken, target wraps past 2^64
    redir_q.push_back(64'h10);
    issue(8'h02, 8'hC1, 64'hFFFF_FFFF_FFFF_FFF0, 64'h20, 64'h0, 1'b0, 1'b0);
    exp_br++;
    chk("wrap_redirect_pc", redirect_pc, 64'h10);
    finish_redirect();
    chk("wrap_taken_cnt", taken_cnt, exp_taken);

    // JALR to a 2-byte aligned target: exception without RVC, redirect with
    exc_q.push_back(64'h8000_1006);
    link_q.push_back(64'h8000_0104);
    issue(8'h80, 8'hC0, 64'h8000_0100, 64'h4, 64'h8000_1003, 1'b0, 1'b1);
    exp_br++;
    chk("jalr_redirect_valid", {63'd0, redirect_valid}, 64'd0);
    chk("jalr_ex_ready", {63'd0, ex_ready}, 64'd1);
    chk("jalr_br_cnt", br_cnt, exp_br);
    chk("jalr_rvc_redirect_valid", {63'd0, c_redirect_valid}, 64'd1);
    chk("jalr_rvc_redirect_pc", c_redirect_pc, 64'h8000_1006);
    chk("jalr_rvc_link_valid", {63'd0, c_link_valid}, 64'd1);
    chk("jalr_rvc_link_data", c_link_data, 64'h8000_0104);
    chk("jalr_rvc_exc_valid", {63'd0, c_exc_valid}, 64'd0);
    c_ready = 1'b1;
    @(posedge clk); #1;
    c_ready = 1'b0;
    chk("jalr_rvc_taken_cnt", c_taken_cnt, 64'd1);

    // JAL with fetch back-pressure for 3 cycles; execute keeps offering work
    redir_q.push_back(64'h2100);
    link_q.push_back(64'h2004);
    issue(8'h40, 8'hC0, 64'h2000, 64'h100, 64'h0, 1'b0, 1'b0);
    exp_br++;
    for (int i = 0; i < 3; i++) begin
      ex_valid = 1'b1; bj_sel = 8'h01; bj_data = 8'hC2; pc = 64'h5000;
      chk("stall_redirect_valid", {63'd0, redirect_valid}, 64'd1);
      chk("stall_redirect_pc", redirect_pc, 64'h2100);
      chk("stall_ex_ready", {63'd0, ex_ready}, 64'd0);
      @(posedge clk); #1;
    end
    ex_valid = 1'b0; bj_sel = '0; bj_data = '0;
    chk("stall_br_cnt", br_cnt, exp_br);
    f0 = n_flush;
    finish_redirect();
    @(posedge clk); #1;
    chk("stall_flush_pulses", 64'(n_flush - f0), 64'd1);
    chk("stall_taken_cnt", taken_cnt, exp_taken);

    // kill while pending and fetch ready: redirect dropped, no flush
    issue(8'h08, 8'hC8, 64'h3000, 64'h20, 64'h0, 1'b0, 1'b0);
    exp_br++;
    chk("kill_pend_redirect_valid", {63'd0, redirect_valid}, 64'd1);
    f0 = n_flush;
    kill = 1'b1; redirect_ready = 1'b1;
    @(posedge clk); #1;
    kill = 1'b0; redirect_ready = 1'b0;
    chk("kill_redirect_valid", {63'd0, redirect_valid}, 64'd0);
    chk("kill_flush", 64'(n_flush - f0), 64'd0);
    chk("kill_taken_cnt", taken_cnt, exp_taken);
    chk("kill_ex_ready", {63'd0, ex_ready}, 64'd1);

    // kill on the accept cycle suppresses everything
    issue(8'h40, 8'hC0, 64'h3100, 64'h40, 64'h0, 1'b1, 1'b0);
    chk("kill_acc_br_cnt", br_cnt, exp_br);
    chk("kill_acc_redirect_valid", {63'd0, redirect_valid}, 64'd0);

    // reset while pending abandons the redirect
    link_q.push_back(64'h4004);
    issue(8'h40, 8'hC0, 64'h4000, 64'h40, 64'h0, 1'b0, 1'b0);
    chk("pre_rst_redirect_valid", {63'd0, redirect_valid}, 64'd1);
    rst = 1'b1; redirect_ready = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; redirect_ready = 1'b0;
    chk("rst_pend_redirect_valid", {63'd0, redirect_valid}, 64'd0);
    chk("rst_pend_redirect_pc", redirect_pc, 64'd0);
    chk("rst_pend_link_data", link_data, 64'd0);
    chk("rst_pend_exc_tval", exc_tval, 64'd0);
    chk("rst_pend_br_cnt", br_cnt, 64'd0);
    chk("rst_pend_taken_cnt", taken_cnt, 64'd0);
    chk("rst_pend_ex_ready", {63'd0, ex_ready}, 64'd1);

    repeat (2) @(posedge clk);
    #1;
    chk("redir_q_drained", 64'(redir_q.size()), 64'd0);
    chk("link_q_drained", 64'(link_q.size()), 64'd0);
    chk("exc_q_drained", 64'(exc_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
